// File: rtl/stage3_seq.sv
// Registered writeback/branch stage: performs the side effect of one decoded
// instruction per handshake, owns power/boot state and counts retirements.
module stage3_seq #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEV_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ORG   = 16'h0044,
  parameter int                    PC_STEP    = 4,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            mblock_s3,
  input  logic [DATA_WIDTH-1:0] vrw_value,
  input  logic [DATA_WIDTH-1:0] vw_value,
  input  logic [DEV_WIDTH-1:0]  vrw_source,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flag_last_zero,
  input  logic                  reset_button,
  input  logic                  exec_ram_set,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_is_write,
  input  logic                  ram_ack,
  output logic [DEV_WIDTH-1:0]  output_devices_address,
  output logic [DATA_WIDTH-1:0] output_devices_value,
  output logic                  output_is_write,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  pc_valid,
  output logic                  is_powered_on,
  output logic                  execute_from_ram,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_RAM_WAIT} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_next_q, pc_cap_q, ram_address_q;
  logic [DATA_WIDTH-1:0] ram_in_q, out_value_q;
  logic [DEV_WIDTH-1:0]  out_addr_q;
  logic                  pc_valid_q, ram_is_write_q, out_write_q, exec_ram_q;
  logic [CNT_WIDTH-1:0]  retired_q;

  logic [ADDR_WIDTH-1:0] pc_step_d, jump_tgt_d;
  logic                  unused_bits;

  assign pc_step_d  = pc + ADDR_WIDTH'(PC_STEP);
  assign jump_tgt_d = vw_value[ADDR_WIDTH-1:0];
  // Only the low address bits of the operands are meaningful for PC/RAM use.
  assign unused_bits = ^{vrw_value, vw_value};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_OFF;
      pc_next_q      <= '0;
      pc_cap_q       <= '0;
      pc_valid_q     <= 1'b0;
      ram_address_q  <= '0;
      ram_in_q       <= '0;
      ram_is_write_q <= 1'b0;
      out_addr_q     <= '0;
      out_value_q    <= '0;
      out_write_q    <= 1'b0;
      exec_ram_q     <= 1'b0;
      retired_q      <= '0;
    end else begin
      pc_valid_q  <= 1'b0;
      out_write_q <= 1'b0;
      if (reset_button) begin
        // Boot wins over everything, including a pending RAM write.
        state_q        <= S_RUN;
        pc_next_q      <= BOOT_ORG;
        pc_valid_q     <= 1'b1;
        exec_ram_q     <= 1'b0;
        ram_is_write_q <= 1'b0;
      end else begin
        if (exec_ram_set) exec_ram_q <= 1'b1;
        case (state_q)
          S_OFF: ;
          S_RUN: begin
            if (in_valid) begin
              case (mblock_s3)
                3'd0: begin
                  pc_next_q  <= pc_step_d;
                  pc_valid_q <= 1'b1;
                  retired_q  <= retired_q + 1'b1;
                end
                3'd1, 3'd3: begin
                  ram_address_q  <= (mblock_s3 == 3'd1) ? ADDR_WIDTH'(vrw_source)
                                                        : vrw_value[ADDR_WIDTH-1:0];
                  ram_in_q       <= vw_value;
                  ram_is_write_q <= 1'b1;
                  pc_cap_q       <= pc;
                  state_q        <= S_RAM_WAIT;
                end
                3'd2: begin
                  out_addr_q  <= vrw_source;
                  out_value_q <= vw_value;
                  out_write_q <= 1'b1;
                  pc_next_q   <= pc_step_d;
                  pc_valid_q  <= 1'b1;
                  retired_q   <= retired_q + 1'b1;
                end
                3'd4: begin
                  pc_next_q  <= jump_tgt_d;
                  pc_valid_q <= 1'b1;
                  retired_q  <= retired_q + 1'b1;
                end
                3'd5, 3'd6: begin
                  pc_next_q  <= ((mblock_s3 == 3'd5) == flag_last_zero) ? jump_tgt_d
                                                                        : pc_step_d;
                  pc_valid_q <= 1'b1;
                  retired_q  <= retired_q + 1'b1;
                end
                3'd7: begin
                  state_q   <= S_OFF;
                  retired_q <= retired_q + 1'b1;
                end
              endcase
            end
          end
          S_RAM_WAIT: begin
            if (ram_is_write_q && ram_ack) begin
              ram_is_write_q <= 1'b0;
              pc_next_q      <= pc_cap_q + ADDR_WIDTH'(PC_STEP);
              pc_valid_q     <= 1'b1;
              retired_q      <= retired_q + 1'b1;
              state_q        <= S_RUN;
            end
          end
          default: state_q <= S_OFF;
        endcase
      end
    end
  end

  assign in_ready               = (state_q == S_RUN);
  assign is_powered_on          = (state_q != S_OFF);
  assign ram_address            = ram_address_q;
  assign ram_in                 = ram_in_q;
  assign ram_is_write           = ram_is_write_q;
  assign output_devices_address = out_addr_q;
  assign output_devices_value   = out_value_q;
  assign output_is_write        = out_write_q;
  assign pc_next                = pc_next_q;
  assign pc_valid               = pc_valid_q;
  assign execute_from_ram       = exec_ram_q;
  assign retired_count          = retired_q;

endmodule

// File: tb/tb_stage3_seq.sv
// Bench for stage3_seq: driver updates a behavioural model and queues expected
// events; a monitor pops and compares whenever the DUT presents them.
module tb_stage3_seq;
  localparam logic [15:0] BOOT = 16'h0044;

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  mblock_s3 = '0;
  logic [31:0] vrw_value = '0, vw_value = '0;
  logic [7:0]  vrw_source = '0;
  logic [15:0] pc = '0;
  logic        flag_last_zero = 1'b0, reset_button = 1'b0, exec_ram_set = 1'b0;
  logic [15:0] ram_address;
  logic [31:0] ram_in;
  logic        ram_is_write, ram_ack = 1'b0;
  logic [7:0]  output_devices_address;
  logic [31:0] output_devices_value;
  logic        output_is_write;
  logic [15:0] pc_next;
  logic        pc_valid, is_powered_on, execute_from_ram;
  logic [15:0] retired_count;

  stage3_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mblock_s3(mblock_s3), .vrw_value(vrw_value), .vw_value(vw_value),
    .vrw_source(vrw_source), .pc(pc), .flag_last_zero(flag_last_zero),
    .reset_button(reset_button), .exec_ram_set(exec_ram_set),
    .ram_address(ram_address), .ram_in(ram_in), .ram_is_write(ram_is_write),
    .ram_ack(ram_ack), .output_devices_address(output_devices_address),
    .output_devices_value(output_devices_value), .output_is_write(output_is_write),
    .pc_next(pc_next), .pc_valid(pc_valid), .is_powered_on(is_powered_on),
    .execute_from_ram(execute_from_ram), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Model: post-edge view of the stage as the driver predicts it.
  bit          m_on = 0, m_wait = 0, m_exec = 0, chk_en = 0;
  logic [15:0] m_count = '0, m_pc = '0;
  logic [15:0] pc_q[$];
  logic [47:0] ram_q[$];
  logic [39:0] out_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic commit(input logic [15:0] nxt);
    pc_q.push_back(nxt);
    m_count = m_count + 16'd1;
  endtask

  task automatic step(input bit iv, input logic [2:0] op, input logic [31:0] vrw,
                      input logic [31:0] vw, input logic [7:0] src, input logic [15:0] p,
                      input bit flag, input bit btn, input bit exs, input bit ack);
    logic [15:0] seq;
    @(negedge clk);
    in_valid = iv; mblock_s3 = op; vrw_value = vrw; vw_value = vw; vrw_source = src;
    pc = p; flag_last_zero = flag; reset_button = btn; exec_ram_set = exs; ram_ack = ack;
    seq = p + 16'd4;
    if (btn) begin
      pc_q.push_back(BOOT);
      m_on = 1; m_wait = 0; m_exec = 0;
    end else begin
      if (exs) m_exec = 1;
      if (m_wait) begin
        if (ack) begin
          commit(m_pc + 16'd4);
          m_wait = 0;
        end
      end else if (m_on && iv) begin
        case (op)
          3'd0: commit(seq);
          3'd1: begin ram_q.push_back({8'h00, src, vw}); m_wait = 1; m_pc = p; end
          3'd3: begin ram_q.push_back({vrw[15:0], vw}); m_wait = 1; m_pc = p; end
          3'd2: begin out_q.push_back({src, vw}); commit(seq); end
          3'd4: commit(vw[15:0]);
          3'd5: commit(flag ? vw[15:0] : seq);
          3'd6: commit(!flag ? vw[15:0] : seq);
          default: begin m_on = 0; m_count = m_count + 16'd1; end
        endcase
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor
  logic [15:0] last_pc = '0;
  logic [47:0] cur_ram = '0;
  logic        prev_wr = 1'b0;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("in_ready", in_ready, m_on && !m_wait);
      check("is_powered_on", is_powered_on, m_on);
      check("execute_from_ram", execute_from_ram, m_exec);
      check("ram_is_write", ram_is_write, m_wait);
      check("retired_count", retired_count, m_count);
      if (pc_valid) begin
        if (pc_q.size() == 0) check("pc_valid_unexpected", 1, 0);
        else begin
          last_pc = pc_q.pop_front();
          check("pc_next", pc_next, last_pc);
        end
      end else check("pc_next_hold", pc_next, last_pc);
      if (output_is_write) begin
        if (out_q.size() == 0) check("out_write_unexpected", 1, 0);
        else check("out_addr_value", {output_devices_address, output_devices_value}, out_q.pop_front());
      end
      if (ram_is_write && !prev_wr) begin
        if (ram_q.size() == 0) begin
          check("ram_write_unexpected", 1, 0);
          cur_ram = {ram_address, ram_in};
        end else cur_ram = ram_q.pop_front();
      end
      if (ram_is_write) check("ram_addr_data", {ram_address, ram_in}, cur_ram);
      prev_wr = ram_is_write;
    end
  end

  initial begin
    bit iv, flag, btn, exs, ack;
    logic [2:0] op;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    check("rst_pc_next", pc_next, 0);
    check("rst_flags", {pc_valid, ram_is_write, output_is_write, execute_from_ram,
                        is_powered_on, in_ready}, 0);
    check("rst_ram", {ram_address, ram_in}, 0);
    check("rst_out", {output_devices_address, output_devices_value}, 0);
    check("rst_count", retired_count, 0);
    @(negedge clk); reset = 0; chk_en = 1;

    // Directed scenarios
    step(1, 3'd0, 0, 0, 0, 16'h1000, 0, 0, 0, 0);       // ignored while off
    step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0);              // boot
    step(1, 3'd0, 0, 0, 0, 16'hFFFE, 0, 0, 0, 0);       // nop wrap -> 0x0002
    step(1, 3'd3, 32'h0000_1234, 32'hDEAD_BEEF, 8'h99, 16'h0200, 0, 0, 0, 0);
    step(1, 3'd0, 0, 0, 0, 16'h0300, 0, 0, 0, 0);       // dropped: not ready
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1);              // ack -> 0x0204
    step(1, 3'd5, 0, 32'h0000_0100, 0, 16'h0020, 1, 0, 0, 0);
    step(1, 3'd6, 0, 32'h0000_0100, 0, 16'h0010, 1, 0, 0, 0);
    step(1, 3'd2, 0, 32'd5, 8'h07, 16'h0014, 0, 0, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 1);              // exec set; stray ack
    step(1, 3'd1, 32'hFFFF_FFFF, 32'hCAFE_0001, 8'h33, 16'h0400, 0, 0, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3'd4, 0, 0, 0, 0, 0, 1, 1, 1);              // boot aborts write
    step(1, 3'd4, 0, 32'h0001_ABCD, 0, 16'h0044, 0, 0, 0, 0);
    step(1, 3'd7, 0, 0, 0, 16'hABCD, 0, 0, 0, 0);       // halt
    step(1, 3'd0, 0, 0, 0, 16'h0050, 0, 0, 0, 0);       // ignored
    idle(2);
    step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      op   = 3'($urandom_range(0, 7));
      if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'd0;
      flag = 1'($urandom_range(0, 1));
      btn  = ($urandom_range(0, 49) == 0) || (!m_on && $urandom_range(0, 4) == 0);
      exs  = ($urandom_range(0, 19) == 0);
      ack  = ($urandom_range(0, 2) == 0);
      step(iv, op, $urandom, $urandom, 8'($urandom), 16'($urandom), flag, btn, exs, ack);
    end
    idle(3);
    check("pc_queue_drained", pc_q.size(), 0);
    check("out_queue_drained", out_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
